// File: rtl/game_timer_pkg.sv
// Shared constants for the round timer: system status codes, timer state
// encoding, BCD limits and the BCD register operation set.
package game_pkg;

    localparam logic [2:0] STAT_NORMAL        = 3'b000;
    localparam logic [2:0] STAT_MATCH_ING     = 3'b001;
    localparam logic [2:0] STAT_MATCH_CANCEL  = 3'b010;
    localparam logic [2:0] STAT_MATCH_SUCCESS = 3'b011;
    localparam logic [2:0] STAT_GAME_INITIAL  = 3'b100;
    localparam logic [2:0] STAT_GAME_CNTDOWN  = 3'b101;
    localparam logic [2:0] STAT_GAME_ING      = 3'b110;
    localparam logic [2:0] STAT_GAME_OVER     = 3'b111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CNTDOWN = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [6:0] BCD_MAX = 7'd99;

    typedef enum logic [1:0] {
        BCD_HOLD,
        BCD_LOAD,
        BCD_DEC,
        BCD_ADD
    } bcd_op_e;

    // Every non-game code (the whole lower half of the code space) parks the timer.
    function automatic logic forces_idle(input logic [2:0] stat);
        return !stat[2];
    endfunction

    // Segment i lights while t > 5*i, i.e. ceil(t/5) segments capped at 16.
    function automatic logic [15:0] therm16(input logic [6:0] t);
        logic [15:0] bar;
        bar = '0;
        for (int i = 0; i < 16; i++) begin
            bar[i] = (32'(t) > 32'(5 * i));
        end
        return bar;
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// Status/bonus handshake and display outputs of the round timer, bundled
// so the state FSM and display side see one port.
interface game_timer_if;

    logic [2:0]  stat_in;
    logic        bonus_req;
    logic        bonus_ack;
    logic [3:0]  time_tens;
    logic [3:0]  time_ones;
    logic [1:0]  cnt_digit;
    logic        time_up;
    logic        warn;
    logic [15:0] led;

    modport master (
        output stat_in, bonus_req,
        input  bonus_ack, time_tens, time_ones, cnt_digit, time_up, warn, led
    );

    modport slave (
        input  stat_in, bonus_req,
        output bonus_ack, time_tens, time_ones, cnt_digit, time_up, warn, led
    );

endinterface

// File: rtl/game_timer_bcd2_updown.sv
// Two-digit BCD register (0..99): load, decrement, or add k with optional
// decrement. Also exposes the binary value being registered this edge.
module bcd2_updown
    import game_pkg::*;
#(
    parameter logic [6:0] RST_VAL = 7'd80
) (
    input  logic       clk_1,
    input  logic       rst,
    input  bcd_op_e    op,
    input  logic [6:0] load_val,
    input  logic [6:0] add_k,
    input  logic       add_dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero,
    output logic [6:0] bin_next
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [6:0] bin_cur;
    logic [7:0] sum;

    assign bin_cur = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum      = {1'b0, bin_cur} + {1'b0, add_k};
        bin_next = bin_cur;
        unique case (op)
            BCD_LOAD: bin_next = load_val;
            BCD_DEC:  bin_next = (bin_cur == 7'd0) ? 7'd0 : bin_cur - 7'd1;
            BCD_ADD: begin
                if (add_dec && sum != 8'd0) sum = sum - 8'd1;
                bin_next = (sum > {1'b0, BCD_MAX}) ? BCD_MAX : sum[6:0];
            end
            default: ;
        endcase
        tens_d = 4'(bin_next / 7'd10);
        ones_d = 4'(bin_next % 7'd10);
    end

    // Zero flag describes the value landing on this edge, so expiry and t=0 coincide.
    assign zero = (bin_next == 7'd0);
    assign tens = tens_q;
    assign ones = ones_q;

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            tens_q <= 4'(RST_VAL / 7'd10);
            ones_q <= 4'(RST_VAL % 7'd10);
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Round timer: 3-2-1 countdown, round clock with line-clear bonuses, BCD/LED
// outputs. Optional macro GAME_TIMER_WARN_BLINK_EN blinks the bar in the last 10 s.
module game_timer
    import game_pkg::*;
#(
    parameter int unsigned GAME_TIME = 80,
    parameter int unsigned BONUS_SEC = 5,
    parameter int unsigned CNT_START = 3
) (
    input logic         clk_1,
    input logic         rst,
    game_timer_if.slave bus
);

    localparam logic [6:0] T_INIT   = 7'(GAME_TIME);
    localparam logic [6:0] BONUS    = 7'(BONUS_SEC);
    localparam logic [1:0] CNT_INIT = 2'(CNT_START);

    logic [1:0]  state_q, state_d, state_base;
    logic [1:0]  cnt_digit_q, cnt_digit_d;
    logic        time_up_q, time_up_d;
    logic        warn_q, warn_d;
    logic        bonus_ack_q, bonus_ack_d;
    logic [15:0] led_q, led_d, bar_next;
    bcd_op_e     bcd_op;
    logic        dec, bonus_take, bcd_zero;
    logic [6:0]  t_next;

    bcd2_updown #(.RST_VAL(T_INIT)) u_time (
        .clk_1    (clk_1),
        .rst      (rst),
        .op       (bcd_op),
        .load_val (T_INIT),
        .add_k    (BONUS),
        .add_dec  (dec),
        .tens     (bus.time_tens),
        .ones     (bus.time_ones),
        .zero     (bcd_zero),
        .bin_next (t_next)
    );

    always_comb begin
        state_base  = state_q;
        cnt_digit_d = cnt_digit_q;
        bcd_op      = BCD_HOLD;
        dec         = 1'b0;
        bonus_take  = 1'b0;
        if (forces_idle(bus.stat_in)) begin
            state_base  = ST_IDLE;
            cnt_digit_d = '0;
            bcd_op      = BCD_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bcd_op = BCD_LOAD;
                    if (bus.stat_in == STAT_GAME_CNTDOWN) begin
                        state_base  = ST_CNTDOWN;
                        cnt_digit_d = CNT_INIT;
                    end else if (bus.stat_in == STAT_GAME_INITIAL ||
                                 bus.stat_in == STAT_GAME_ING) begin
                        state_base = ST_RUN;
                    end
                end
                ST_CNTDOWN: begin
                    if (cnt_digit_q <= 2'd1) begin
                        state_base  = ST_RUN;
                        cnt_digit_d = '0;
                        bcd_op      = BCD_LOAD;
                    end else begin
                        cnt_digit_d = cnt_digit_q - 2'd1;
                    end
                end
                ST_RUN: begin
                    dec        = (bus.stat_in == STAT_GAME_ING);
                    // A request seen while ack is high is the same request; skip that cycle.
                    bonus_take = bus.bonus_req && !bonus_ack_q;
                    if (bonus_take)  bcd_op = BCD_ADD;
                    else if (dec)    bcd_op = BCD_DEC;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = (state_base == ST_RUN && bcd_zero) ? ST_EXPIRED : state_base;
        time_up_d   = (state_d == ST_EXPIRED);
        warn_d      = (state_d == ST_RUN) && (t_next <= 7'd10);
        bonus_ack_d = bonus_take;
        bar_next    = therm16(t_next);
    end

`ifdef GAME_TIMER_WARN_BLINK_EN
    logic blink_q, blink_d;

    // Phase restarts "shown" whenever the warning zone is freshly entered.
    always_comb begin
        blink_d = (warn_d && warn_q) ? !blink_q : 1'b1;
        led_d   = (warn_d && !blink_d) ? 16'h0000 : bar_next;
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) blink_q <= 1'b1;
        else     blink_q <= blink_d;
    end
`else
    assign led_d = bar_next;
`endif

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_digit_q <= '0;
            time_up_q   <= 1'b0;
            warn_q      <= 1'b0;
            bonus_ack_q <= 1'b0;
            led_q       <= therm16(T_INIT);
        end else begin
            state_q     <= state_d;
            cnt_digit_q <= cnt_digit_d;
            time_up_q   <= time_up_d;
            warn_q      <= warn_d;
            bonus_ack_q <= bonus_ack_d;
            led_q       <= led_d;
        end
    end

    assign bus.cnt_digit = cnt_digit_q;
    assign bus.time_up   = time_up_q;
    assign bus.warn      = warn_q;
    assign bus.bonus_ack = bonus_ack_q;
    assign bus.led       = led_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: countdown, full round, bonuses, saturation,
// pending requests, and async reset. Honors GAME_TIMER_WARN_BLINK_EN for the bar.
module tb_game_timer;
    import game_pkg::*;

    logic clk_1 = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    game_timer_if bus ();

    game_timer #(.GAME_TIME(80), .BONUS_SEC(5), .CNT_START(3)) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_1 = ~clk_1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int t);
        check({tag, "_tens"}, 32'(bus.time_tens), 32'(t / 10));
        check({tag, "_ones"}, 32'(bus.time_ones), 32'(t % 10));
    endtask

    task automatic check_reset(input string tag);
        check_time(tag, 80);
        check({tag, "_cnt"},  32'(bus.cnt_digit), 0);
        check({tag, "_up"},   32'(bus.time_up),   0);
        check({tag, "_warn"}, 32'(bus.warn),      0);
        check({tag, "_ack"},  32'(bus.bonus_ack), 0);
        check({tag, "_led"},  32'(bus.led),       32'h0000_FFFF);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_1);
        #1;
    endtask

    function automatic logic [15:0] bar(input int t);
        int n;
        n = (t + 4) / 5;
        if (n > 16) n = 16;
        return 16'((32'd1 << n) - 1);
    endfunction

    // Valid for a plain descending run that enters t=10 from t=11.
    function automatic logic [15:0] exp_led(input int t);
`ifdef GAME_TIMER_WARN_BLINK_EN
        if (t >= 1 && t <= 10 && ((10 - t) % 2 == 1)) return 16'h0000;
`endif
        return bar(t);
    endfunction

    task automatic bonus_once();
        bus.bonus_req = 1'b1;
        step(1);
        check("bonus_once_ack", 32'(bus.bonus_ack), 1);
        bus.bonus_req = 1'b0;
        step(1);
    endtask

    initial begin
        int t;
        rst = 1'b0;
        bus.stat_in   = STAT_NORMAL;
        bus.bonus_req = 1'b0;
        #1 rst = 1'b1;
        #2 check_reset("por");
        #5 rst = 1'b0;

        step(5);
        check_reset("idle");

        // Countdown 3,2,1 then RUN with cnt_digit 0.
        bus.stat_in = STAT_GAME_CNTDOWN;
        step(1); check("cnt3", 32'(bus.cnt_digit), 3); check_time("cnt3", 80);
        step(1); check("cnt2", 32'(bus.cnt_digit), 2);
        step(1); check("cnt1", 32'(bus.cnt_digit), 1);
        bus.stat_in = STAT_GAME_ING;
        step(1); check("cnt0", 32'(bus.cnt_digit), 0); check_time("run_entry", 80);
        check("run_entry_warn", 32'(bus.warn), 0);

        for (int i = 1; i <= 80; i++) begin
            step(1);
            t = 80 - i;
            check_time("run", t);
            check("run_led",  32'(bus.led),     32'(exp_led(t)));
            check("run_warn", 32'(bus.warn),    32'(t <= 10 && t > 0));
            check("run_up",   32'(bus.time_up), 32'(t == 0));
            if (t == 40) check("led_at_40", 32'(bus.led), 32'h0000_00FF);
            if (t == 10) check("warn_at_10", 32'(bus.warn), 1);
        end

        bus.stat_in = STAT_GAME_OVER;
        step(2);
        check("over_hold_up", 32'(bus.time_up), 1);
        check_time("over_hold", 0);
        check("over_led", 32'(bus.led), 0);
        bus.stat_in = STAT_NORMAL;
        step(1);
        check_reset("back_idle");

        // Direct start without countdown, run down to 20.
        bus.stat_in = STAT_GAME_ING;
        step(1); check_time("direct_run", 80); check("direct_cnt", 32'(bus.cnt_digit), 0);
        step(60); check_time("at20", 20);

        // Request dropped when ack seen: one bonus, net +4.
        bus.bonus_req = 1'b1;
        step(1); check_time("bonus1", 24); check("bonus1_ack", 32'(bus.bonus_ack), 1);
        bus.bonus_req = 1'b0;
        step(1); check_time("bonus1_after", 23); check("bonus1_ack_low", 32'(bus.bonus_ack), 0);

        // Request held one extra cycle: second bonus on the following cycle.
        bus.bonus_req = 1'b1;
        step(1); check_time("dbl_a", 27); check("dbl_a_ack", 32'(bus.bonus_ack), 1);
        step(1); check_time("dbl_b", 26); check("dbl_b_ack", 32'(bus.bonus_ack), 0);
        step(1); check_time("dbl_c", 30); check("dbl_c_ack", 32'(bus.bonus_ack), 1);
        bus.bonus_req = 1'b0;
        step(1); check_time("dbl_d", 29); check("dbl_d_ack", 32'(bus.bonus_ack), 0);

        // Mid-RUN abort, then a request pending in IDLE is kept until RUN.
        bus.stat_in = STAT_NORMAL;
        step(1); check_reset("abort");
        bus.bonus_req = 1'b1;
        step(2); check("pend_idle_ack", 32'(bus.bonus_ack), 0); check_time("pend_idle", 80);
        bus.stat_in = STAT_GAME_ING;
        step(1); check("pend_entry_ack", 32'(bus.bonus_ack), 0); check_time("pend_entry", 80);
        step(1); check("pend_take_ack", 32'(bus.bonus_ack), 1); check_time("pend_take", 84);
        bus.bonus_req = 1'b0;
        step(1); check_time("pend_after", 83);

        // Climb to 97 with the clock held, then saturate at 99.
        step(1); check_time("pre97", 82);
        bus.stat_in = STAT_GAME_INITIAL;
        bonus_once(); bonus_once(); bonus_once();
        check_time("at97", 97);
        bonus_once();
        check_time("sat_hold", 99);
        bus.stat_in = STAT_GAME_ING;
        bus.bonus_req = 1'b1;
        step(1); check_time("sat_dec", 99); check("sat_dec_ack", 32'(bus.bonus_ack), 1);
        bus.bonus_req = 1'b0;
        step(1); check_time("after_sat", 98);

        // Bonus at t=1 rescues the round.
        step(97);
        check_time("at1", 1);
        check("at1_warn", 32'(bus.warn), 1);
        check("at1_led",  32'(bus.led), 32'(exp_led(1)));
        bus.bonus_req = 1'b1;
        step(1);
        check_time("rescue", 5);
        check("rescue_up",  32'(bus.time_up),   0);
        check("rescue_ack", 32'(bus.bonus_ack), 1);
        check("rescue_led", 32'(bus.led), 32'(bar(5)));
        bus.bonus_req = 1'b0;
        step(1); check_time("rescue_after", 4); check("rescue_after_up", 32'(bus.time_up), 0);

        // Async reset in the middle of the countdown.
        bus.stat_in = STAT_NORMAL;
        step(1); check_reset("pre_cnt");
        bus.stat_in = STAT_GAME_CNTDOWN;
        step(2); check("mid_cnt", 32'(bus.cnt_digit), 2);
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        bus.stat_in = STAT_NORMAL;
        #2 rst = 1'b0;
        step(1); check_reset("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
